fp_stream_accumulator: RTL and testbench
========================================

// Module: fp_stream_accumulator
// PURPOSE
//   Sequential front-end for the combinational FP32 adder: accepts a stream of IEEE-754
//   single-precision operands over a valid/ready handshake and drives the adder with
//   (running sum, new operand). It registers the adder result as the new running sum.
//   After LEN operands it presents the final sum on a held valid/ready output.
//   The adder is instantiated alongside this block in the parent; this block holds all state.
// PARAMETERS
//   LEN_W   8   width of the operand-count field; max stream length is 2**LEN_W-1
// PORTS
//   clk         in   1        single clock, rising edge
//   rst_n       in   1        asynchronous, active-low reset
//   start       in   1        pulse: begin a new accumulation (honoured only in IDLE)
//   len         in   LEN_W    operand count, sampled on accepted start
//   abort       in   1        abandon the current accumulation, return to IDLE, no output
//   in_valid    in   1        operand valid
//   in_ready    out  1        block can accept an operand this cycle
//   in_data     in   32       FP32 operand
//   add_a       out  32       to adder input a = running sum register
//   add_b       out  32       to adder input b = in_data (combinational pass-through)
//   add_result  in   32       from adder result (combinational, same cycle)
//   out_valid   out  1        final sum valid; held until out_ready
//   out_ready   in   1        consumer accepts out_sum
//   out_sum     out  32       final FP32 sum (= running sum register)
//   busy        out  1        state != IDLE
//   count       out  LEN_W    operands accepted so far in current run
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, sum_q=32'h0, cnt=0, len_q=0.
//     Resulting outputs: in_ready=0, out_valid=0, busy=0, out_sum=0, count=0.
//   FSM: IDLE / ACCUM / DONE. All outputs are decoded from registers except add_b (= in_data).
//   IDLE: in_ready=0.
//     start & len!=0 -> len_q<=len, sum_q<=0, cnt<=0, go ACCUM.
//     start & len==0 -> sum_q<=0, go DONE. Output is 0.0.
//   ACCUM: in_ready=1. On accept (in_valid&in_ready): sum_q<=add_result, cnt<=cnt+1.
//     Throughput is 1 operand/cycle.
//     Accept with cnt==len_q-1 -> go DONE; out_valid rises the next cycle (latency 1 from last accept).
//   DONE: out_valid=1, out_sum=sum_q stable, in_ready=0.
//     out_ready -> IDLE. out_valid drops the next cycle.
//     start in the same cycle as out_ready is ignored.
//   start outside IDLE is ignored; len is not re-sampled.
//   abort in ACCUM or DONE -> IDLE next cycle; sum_q and cnt are cleared.
//     abort beats a simultaneous accept: the operand is consumed but discarded.
//     abort in IDLE has no effect.
//   sum_q starts at 32'h0, so the adder's zero-passthrough makes the first accept load the operand exactly.
//   No NaN/Inf/denormal handling here; operands and results are treated as opaque 32-bit data.
//   cnt never wraps: len_q <= 2**LEN_W-1 and the FSM leaves ACCUM at cnt==len_q-1.
//   Reset asserted mid-run discards everything immediately; no output is produced.
// STRUCTURE
//   Shared package fp_pkg:
//     FP32_W=32, FP32_ZERO=32'h0000_0000
//     state typedef {S_IDLE,S_ACCUM,S_DONE}
//     fields SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23
//   No sub-module: one FSM plus sum/count/len registers in a single file.
//   The FP32 adder is instantiated by the parent, never inside this block.
// TESTING (bench instantiates this block + the FP32 adder)
//   1. Reset: rst_n=0 mid-ACCUM -> same-cycle in_ready=0, busy=0, out_valid=0, count=0.
//   2. start,len=3; stream 3F800000,40000000,40400000 back-to-back
//        -> out_valid 1 cycle after 3rd accept, out_sum=40C00000 (6.0).
//   3. start,len=2; stream 3F800000,BF800000 -> out_sum=00000000. Hold out_ready=0 for 5 cycles
//        -> out_valid and out_sum stable throughout; IDLE 1 cycle after out_ready.
//   4. start,len=0 -> DONE next cycle with out_sum=0, in_ready never high.
//   5. len=4, in_valid toggled 1/0/1/0/... -> count increments only on accept cycles; result equals the gap-free run.
//   6. abort after 2 of 4 accepts (also abort together with an accept) -> IDLE, no out_valid.
//        A following start,len=1 with 40000000 -> out_sum=40000000 (no stale sum).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 constants, field positions and the accumulator FSM state type.
package fp_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_stream_accumulator.sv
// Streams FP32 operands into an external combinational adder, keeps the running
// sum, and presents the final sum on a held valid/ready output after LEN operands.
module fp_stream_accumulator
  import fp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_data,
  output logic [FP32_W-1:0] add_a,
  output logic [FP32_W-1:0] add_b,
  input  logic [FP32_W-1:0] add_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_sum,
  output logic              busy,
  output logic [LEN_W-1:0]  count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and out_valid holds until taken.

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t            state_q, state_d;
  logic [FP32_W-1:0] sum_q, sum_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sum_q   <= FP32_ZERO;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign accept = in_valid && (state_q == S_ACCUM);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d = FP32_ZERO;
          cnt_d = '0;
          len_d = len;
          state_d = (len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        // Abort wins over a same-cycle accept; that operand is dropped.
        if (abort) begin
          sum_d   = FP32_ZERO;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          sum_d = add_result;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == (len_q - CNT_ONE)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          sum_d   = FP32_ZERO;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Everything except add_b is decoded from registers.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign add_a     = sum_q;
  assign add_b     = in_data;
  assign count     = cnt_q;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator with a behavioural FP32 adder model
// closing the add_a/add_b/add_result loop; output sums checked via expected queue.
module tb_fp_stream_accumulator;
  import fp_pkg::*;

  localparam int LEN_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [FP32_W-1:0] in_data;
  logic [FP32_W-1:0] add_a;
  logic [FP32_W-1:0] add_b;
  logic [FP32_W-1:0] add_result;
  logic              out_valid;
  logic              out_ready;
  logic [FP32_W-1:0] out_sum;
  logic              busy;
  logic [LEN_W-1:0]  count;

  logic [FP32_W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  fp_stream_accumulator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FP32 adder model (normal numbers, truncating) ----------------
  function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [7:0]  ea, eb, d;
    logic [27:0] ma, mb, m;
    if (a_in[EXP_MSB:EXP_LSB] == 8'd0) return b_in;
    if (b_in[EXP_MSB:EXP_LSB] == 8'd0) return a_in;
    if (b_in[30:0] > a_in[30:0]) begin a = b_in; b = a_in; end
    else begin a = a_in; b = b_in; end
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    ma = {2'b01, a[MAN_W-1:0], 3'b000};
    mb = {2'b01, b[MAN_W-1:0], 3'b000};
    d  = ea - eb;
    mb = (d > 8'd26) ? 28'd0 : (mb >> d);
    if (a[SIGN_BIT] == b[SIGN_BIT]) begin
      m = ma + mb;
      if (m[27]) begin m = m >> 1; ea = ea + 8'd1; end
    end else begin
      m = ma - mb;
      if (m == 28'd0) return FP32_ZERO;
      for (int i = 0; i < 27; i++) begin
        if (!m[26]) begin m = m << 1; ea = ea - 8'd1; end
      end
    end
    return {a[SIGN_BIT], ea, m[25:3]};
  endfunction

  assign add_result = fp_add(add_a, add_b);

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got %h expected none at %0t", out_sum, $time);
      end else begin
        check("out_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [31:0] d);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        tick();
        break;
      end
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out();
    bit got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        tick();
        break;
      end
    end
    out_ready = 1'b0;
    if (!got) check("out_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] stream4[4];
    stream4[0] = 32'h3F80_0000;
    stream4[1] = 32'h4000_0000;
    stream4[2] = 32'h3F00_0000;
    stream4[3] = 32'h4080_0000;

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1.0 + 2.0 + 3.0 = 6.0, back-to-back
    do_start(8'd3);
    send(32'h3F80_0000);
    send(32'h4000_0000);
    send(32'h4040_0000);
    in_valid = 1'b0;
    check("t2_valid_latency", 32'(out_valid), 32'd1);
    check("t2_count", 32'(count), 32'd3);
    exp_q.push_back(32'h40C0_0000);
    wait_out();
    check("t2_valid_drop", 32'(out_valid), 32'd0);

    // 1.0 + -1.0 = 0, held output; a start while DONE is ignored
    do_start(8'd2);
    send(32'h3F80_0000);
    send(32'hBF80_0000);
    in_valid = 1'b0;
    start = 1'b1; len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_sum", out_sum, 32'h0);
      check("t3_hold_count", 32'(count), 32'd2);
      tick();
      start = 1'b0;
    end
    exp_q.push_back(32'h0000_0000);
    wait_out();
    check("t3_idle_after", 32'(busy), 32'd0);

    // len=0 goes straight to DONE; start with out_ready is ignored
    do_start(8'd0);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_sum", out_sum, 32'h0);
    exp_q.push_back(32'h0000_0000);
    start = 1'b1; len = 8'd3;
    wait_out();
    start = 1'b0;
    check("t4_start_ignored", 32'(busy), 32'd0);

    // len=4 with gaps between operands: 1 + 2 + 0.5 + 4 = 7.5
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      send(stream4[i]);
      in_valid = 1'b0;
      check("t5_count_acc", 32'(count), 32'(i + 1));
      if (i < 3) begin
        tick();
        check("t5_count_gap", 32'(count), 32'(i + 1));
      end
    end
    exp_q.push_back(32'h40F0_0000);
    wait_out();

    // same stream without gaps must give the same sum
    do_start(8'd4);
    for (int i = 0; i < 4; i++) send(stream4[i]);
    in_valid = 1'b0;
    exp_q.push_back(32'h40F0_0000);
    wait_out();

    // abort after 2 of 4 accepts
    do_start(8'd4);
    send(32'h3F80_0000);
    send(32'h4000_0000);
    in_valid = 1'b0;
    check("t6_count_pre", 32'(count), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_count", 32'(count), 32'd0);
    check("t6_abort_valid", 32'(out_valid), 32'd0);

    // abort together with an accept
    do_start(8'd4);
    send(32'h3F80_0000);
    in_data = 32'h4000_0000;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("t6_abort_acc_busy", 32'(busy), 32'd0);
    check("t6_abort_acc_count", 32'(count), 32'd0);
    check("t6_abort_acc_sum", out_sum, 32'h0);

    // no stale sum after abort
    do_start(8'd1);
    send(32'h4000_0000);
    in_valid = 1'b0;
    exp_q.push_back(32'h4000_0000);
    wait_out();

    // reset mid-ACCUM takes effect immediately
    do_start(8'd3);
    send(32'h3F80_0000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_in_ready", 32'(in_ready), 32'd0);
    check("t1_rst_busy", 32'(busy), 32'd0);
    check("t1_rst_valid", 32'(out_valid), 32'd0);
    check("t1_rst_count", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t1_post_rst_busy", 32'(busy), 32'd0);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
